// File: rtl/vred_pkg.sv
// vred_pkg: shared types and constants for the vALU reduction sequencer.
//   - opcode enum, SEW codes, reduction-unit opSel constants
//   - FSM state enum
//   - helpers: fold_passes, sew_mask, op_legal, op_opsel
// Optional feature macro: VRED_SEQ_MINMAX_EN (enables MIN/MAX/MINU/MAXU).
package vred_pkg;

  typedef enum logic [2:0] {
    OP_SUM  = 3'd0,
    OP_MIN  = 3'd1,
    OP_MAX  = 3'd2,
    OP_MINU = 3'd3,
    OP_MAXU = 3'd4
  } vred_op_e;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  localparam logic [8:0] OPSEL_SUM  = 9'h001;
  localparam logic [8:0] OPSEL_MIN  = 9'h002;
  localparam logic [8:0] OPSEL_MAX  = 9'h004;
  localparam logic [8:0] OPSEL_MINU = 9'h008;
  localparam logic [8:0] OPSEL_MAXU = 9'h010;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FIRST      = 4'd1,
    S_ACC_ISSUE  = 4'd2,
    S_ACC_WAIT   = 4'd3,
    S_FOLD_ISSUE = 4'd4,
    S_FOLD_WAIT  = 4'd5,
    S_SCAL_ISSUE = 4'd6,
    S_SCAL_WAIT  = 4'd7,
    S_DONE       = 4'd8
  } vred_state_e;

  // Horizontal halving passes needed to bring a 64-bit word down to one lane.
  function automatic logic [1:0] fold_passes(input logic [1:0] sew);
    return 2'd3 - sew;
  endfunction

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    logic [63:0] m;
    unique case (sew)
      SEW_8:   m = 64'h0000_0000_0000_00FF;
      SEW_16:  m = 64'h0000_0000_0000_FFFF;
      SEW_32:  m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
`ifdef VRED_SEQ_MINMAX_EN
    return op <= OP_MAXU;
`else
    return op == OP_SUM;
`endif
  endfunction

  function automatic logic [8:0] op_opsel(input logic [2:0] op);
    logic [8:0] s;
    s = '0;
    case (op)
      OP_SUM:  s = OPSEL_SUM;
`ifdef VRED_SEQ_MINMAX_EN
      OP_MIN:  s = OPSEL_MIN;
      OP_MAX:  s = OPSEL_MAX;
      OP_MINU: s = OPSEL_MINU;
      OP_MAXU: s = OPSEL_MAXU;
`endif
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vred_fold_mux.sv
// vred_fold_mux: combinational operand builder for the reduction unit.
//   state_i      current sequencer state
//   word_valid_i input-stream valid (issue in ACC_ISSUE only on handshake)
//   pass_i       fold pass index (0 = 64-bit width)
//   word_i/acc_i/seed_i operand sources
//   en_o, vec_o  red_en / red_vec toward the reduction unit (zero when idle)
module vred_fold_mux
  import vred_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  vred_state_e               state_i,
  input  logic                      word_valid_i,
  input  logic [1:0]                pass_i,
  input  logic [DATA_WIDTH-1:0]     word_i,
  input  logic [DATA_WIDTH-1:0]     acc_i,
  input  logic [DATA_WIDTH-1:0]     seed_i,
  output logic                      en_o,
  output logic [2*DATA_WIDTH-1:0]   vec_o
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH) + 1;

  logic [SHW-1:0] half_sh;

  // Pass k folds width W = DATA_WIDTH>>k, so the upper half sits W/2 above.
  assign half_sh = SHW'(DATA_WIDTH / 2) >> pass_i;

  always_comb begin
    en_o  = 1'b0;
    vec_o = '0;
    case (state_i)
      S_ACC_ISSUE: begin
        if (word_valid_i) begin
          en_o  = 1'b1;
          vec_o = {word_i, acc_i};
        end
      end
      S_FOLD_ISSUE: begin
        en_o  = 1'b1;
        vec_o = {acc_i >> half_sh, acc_i};
      end
      S_SCAL_ISSUE: begin
        en_o  = 1'b1;
        vec_o = {seed_i, acc_i};
      end
      default: begin
        en_o  = 1'b0;
        vec_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/vred_seq.sv
// vred_seq: reduction sequencer for the vALU reduction path.
//   Takes one command (op, sew, n_words, scalar seed), streams packed words
//   through the shared single-cycle reduction unit, folds the accumulator
//   horizontally, combines with the seed and returns a SEW-wide scalar.
// Ports:
//   clk, rst (async active-low)
//   start/op/sew/n_words/scalar      command (sampled in IDLE only)
//   in_valid/in_data/in_ready        packed word stream
//   red_en/red_vec/red_sew/red_opsel drive to reduction unit; red_out result
//   busy, out_valid/out_ready/out_data/out_err  result port
// Optional feature macro: VRED_SEQ_MINMAX_EN (MIN/MAX/MINU/MAXU legal).
module vred_seq
  import vred_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned OPSEL_WIDTH = 9,
  parameter int unsigned SEW_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [SEW_WIDTH-1:0]     sew,
  input  logic [CNT_WIDTH-1:0]     n_words,
  input  logic [DATA_WIDTH-1:0]    scalar,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     red_en,
  output logic [2*DATA_WIDTH-1:0]  red_vec,
  output logic [SEW_WIDTH-1:0]     red_sew,
  output logic [OPSEL_WIDTH-1:0]   red_opsel,
  input  logic [DATA_WIDTH-1:0]    red_out,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_err
);

  vred_state_e            state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [SEW_WIDTH-1:0]   sew_q, sew_d;
  logic [DATA_WIDTH-1:0]  seed_q, seed_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [1:0]             pass_q, pass_d;
  logic                   err_q, err_d;
  vred_state_e            fold_entry;

  // SEW=64 has no fold passes and goes straight to the seed combine.
  assign fold_entry = (fold_passes(sew_q) == 2'd0) ? S_SCAL_ISSUE : S_FOLD_ISSUE;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sew_d   = sew_q;
    seed_d  = seed_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          sew_d  = sew;
          seed_d = scalar & sew_mask(sew);
          rem_d  = n_words;
          err_d  = 1'b0;
          pass_d = 2'd0;
          if (!op_legal(op)) begin
            err_d   = 1'b1;
            acc_d   = '0;
            state_d = S_DONE;
          end else if (n_words == '0) begin
            acc_d   = scalar & sew_mask(sew);
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        if (in_valid) begin
          acc_d   = in_data;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q != CNT_WIDTH'(1)) ? S_ACC_ISSUE : fold_entry;
        end
      end
      S_ACC_ISSUE: begin
        if (in_valid) state_d = S_ACC_WAIT;
      end
      S_ACC_WAIT: begin
        acc_d   = red_out;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q != CNT_WIDTH'(1)) ? S_ACC_ISSUE : fold_entry;
      end
      S_FOLD_ISSUE: state_d = S_FOLD_WAIT;
      S_FOLD_WAIT: begin
        acc_d   = red_out;
        pass_d  = pass_q + 2'd1;
        state_d = ((pass_q + 2'd1) == fold_passes(sew_q)) ? S_SCAL_ISSUE : S_FOLD_ISSUE;
      end
      S_SCAL_ISSUE: state_d = S_SCAL_WAIT;
      S_SCAL_WAIT: begin
        acc_d   = red_out;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sew_q   <= '0;
      seed_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sew_q   <= sew_d;
      seed_q  <= seed_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  vred_fold_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fold_mux (
    .state_i      (state_q),
    .word_valid_i (in_valid),
    .pass_i       (pass_q),
    .word_i       (in_data),
    .acc_i        (acc_q),
    .seed_i       (seed_q),
    .en_o         (red_en),
    .vec_o        (red_vec)
  );

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_FIRST) || (state_q == S_ACC_ISSUE);
  assign out_valid = (state_q == S_DONE);
  assign out_err   = (state_q == S_DONE) && err_q;
  assign out_data  = (state_q == S_DONE) ? (acc_q & sew_mask(sew_q)) : '0;
  assign red_sew   = sew_q;
  assign red_opsel = (state_q == S_IDLE) ? '0 : op_opsel(op_q);

endmodule
